// File: rtl/cmos_decode_v2.sv
// cmos_decode_v2: DVP byte-bus capture, pixel packing and geometry checks.
// Pins are registered once; everything downstream runs off that stage.
module cmos_decode_v2 #(
    parameter int DATA_W        = 8,
    parameter int BYTES_PER_PIX = 2,
    parameter int MSB_FIRST     = 1,
    parameter int FRAME_WAITCNT = 15,
    parameter int H_ACTIVE      = 640,
    parameter int V_ACTIVE      = 480
) (
    input  logic                            cmos_pclk_i,
    input  logic                            rst_n_i,
    input  logic                            cmos_href_i,
    input  logic                            cmos_vsync_i,
    input  logic [DATA_W-1:0]               cmos_data_i,
    output logic [DATA_W*BYTES_PER_PIX-1:0] pix_o,
    output logic                            de_o,
    output logic                            sof_o,
    output logic                            eol_o,
    output logic [$clog2(H_ACTIVE)-1:0]     x_o,
    output logic [$clog2(V_ACTIVE)-1:0]     y_o,
    output logic [15:0]                     frame_cnt_o,
    output logic                            out_en_o,
    output logic                            line_err_o,
    output logic                            frame_err_o
);

    localparam int PW = DATA_W * BYTES_PER_PIX;
    localparam int XW = $clog2(H_ACTIVE);
    localparam int YW = $clog2(V_ACTIVE);
    localparam int CW = $clog2(H_ACTIVE + 1);
    localparam int LW = $clog2(V_ACTIVE + 1);

    localparam logic [7:0]    WAITN  = 8'(FRAME_WAITCNT);
    localparam logic [1:0]    B_LAST = 2'(BYTES_PER_PIX - 1);
    localparam logic [CW-1:0] H_MAX  = CW'(H_ACTIVE);
    localparam logic [LW-1:0] V_MAX  = LW'(V_ACTIVE);
    localparam logic [LW-1:0] V_LAST = LW'(V_ACTIVE - 1);

    typedef enum logic [1:0] {ST_WAIT, ST_SYNC, ST_FRAME} state_t;

    state_t            state_q;
    logic              href_s1_q;
    logic              vs_s1_q;
    logic              href_s2_q;
    logic              vs_s2_q;
    logic [DATA_W-1:0] data_s1_q;
    logic [1:0]        beat_q;
    logic [PW-1:0]     asm_q;
    logic [PW-1:0]     asm_d;
    logic [PW-1:0]     pix_q;
    logic [CW-1:0]     col_q;
    logic              col_ovf_q;
    logic [LW-1:0]     line_q;
    logic              line_ovf_q;
    logic [7:0]        wait_q;
    logic [7:0]        wait_inc;
    logic [15:0]       fcnt_q;
    logic              de_q;
    logic              sof_q;
    logic              eol_q;
    logic              out_en_q;
    logic              lerr_q;
    logic              ferr_q;
    logic [XW-1:0]     x_q;
    logic [YW-1:0]     y_q;

    logic vs_fall;
    logic href_fall;
    logic last_beat;
    logic pix_evt;
    logic col_in;
    logic line_in;
    logic in_frame;
    logic de_d;
    logic line_cls;
    logic line_bad;
    logic frame_ok;

    assign vs_fall   = vs_s2_q & ~vs_s1_q;
    assign href_fall = href_s2_q & ~href_s1_q;
    assign last_beat = beat_q == B_LAST;
    assign pix_evt   = href_s1_q & last_beat;
    assign col_in    = col_q < H_MAX;
    assign line_in   = line_q < V_MAX;
    assign in_frame  = state_q == ST_FRAME;
    assign de_d      = pix_evt & in_frame & out_en_q & col_in & line_in;
    assign line_cls  = href_fall & in_frame;
    assign line_bad  = (col_q != H_MAX) | col_ovf_q | (beat_q != 2'd0);
    assign wait_inc  = wait_q + 8'd1;

    // A line closing in the same cycle as vs_fall still counts toward this frame.
    assign frame_ok  = ~line_ovf_q &
                       (line_cls ? (line_q == V_LAST) : (line_q == V_MAX));

    assign asm_d = (MSB_FIRST != 0)
                 ? ((asm_q << DATA_W) | PW'(data_s1_q))
                 : ((asm_q >> DATA_W) | (PW'(data_s1_q) << (PW - DATA_W)));

    always_ff @(posedge cmos_pclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            href_s1_q <= 1'b0;
            vs_s1_q   <= 1'b0;
            href_s2_q <= 1'b0;
            vs_s2_q   <= 1'b0;
            data_s1_q <= '0;
        end else begin
            href_s1_q <= cmos_href_i;
            vs_s1_q   <= cmos_vsync_i;
            data_s1_q <= cmos_data_i;
            href_s2_q <= href_s1_q;
            vs_s2_q   <= vs_s1_q;
        end
    end

    always_ff @(posedge cmos_pclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            beat_q    <= '0;
            asm_q     <= '0;
            pix_q     <= '0;
            col_q     <= '0;
            col_ovf_q <= 1'b0;
            de_q      <= 1'b0;
            sof_q     <= 1'b0;
            eol_q     <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
        end else begin
            if (href_s1_q) begin
                beat_q <= last_beat ? 2'd0 : beat_q + 2'd1;
                asm_q  <= asm_d;
            end else begin
                beat_q <= 2'd0;
            end
            if (pix_evt) begin
                pix_q <= asm_d;
            end
            if (href_fall) begin
                col_q     <= '0;
                col_ovf_q <= 1'b0;
            end else if (pix_evt) begin
                if (col_in) begin
                    col_q <= col_q + CW'(1);
                end else begin
                    col_ovf_q <= 1'b1;
                end
            end
            de_q  <= de_d;
            sof_q <= de_d & (col_q == '0) & (line_q == '0);
            eol_q <= de_d & (col_q == CW'(H_ACTIVE - 1));
            if (de_d) begin
                x_q <= col_q[XW-1:0];
                y_q <= line_q[YW-1:0];
            end
        end
    end

    always_ff @(posedge cmos_pclk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_WAIT;
            wait_q     <= '0;
            out_en_q   <= 1'b0;
            fcnt_q     <= '0;
            line_q     <= '0;
            line_ovf_q <= 1'b0;
            lerr_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            lerr_q <= line_cls & line_bad;
            ferr_q <= 1'b0;
            if (line_cls) begin
                if (line_in) begin
                    line_q <= line_q + LW'(1);
                end else begin
                    line_ovf_q <= 1'b1;
                end
            end
            unique case (state_q)
                ST_WAIT: begin
                    if (FRAME_WAITCNT == 0) begin
                        out_en_q <= 1'b1;
                        state_q  <= ST_SYNC;
                    end else if (vs_fall) begin
                        wait_q <= wait_inc;
                        if (wait_inc == WAITN) begin
                            out_en_q <= 1'b1;
                            state_q  <= ST_SYNC;
                        end
                    end
                end
                ST_SYNC: begin
                    if (vs_fall) begin
                        line_q     <= '0;
                        line_ovf_q <= 1'b0;
                        state_q    <= ST_FRAME;
                    end
                end
                ST_FRAME: begin
                    if (vs_fall) begin
                        if (frame_ok) begin
                            fcnt_q <= fcnt_q + 16'd1;
                        end else begin
                            ferr_q <= 1'b1;
                        end
                        line_q     <= '0;
                        line_ovf_q <= 1'b0;
                    end
                end
                default: state_q <= ST_WAIT;
            endcase
        end
    end

    assign pix_o       = pix_q;
    assign de_o        = de_q;
    assign sof_o       = sof_q;
    assign eol_o       = eol_q;
    assign x_o         = x_q;
    assign y_o         = y_q;
    assign frame_cnt_o = fcnt_q;
    assign out_en_o    = out_en_q;
    assign line_err_o  = lerr_q;
    assign frame_err_o = ferr_q;

endmodule

// File: tb/tb_cmos_decode_v2.sv
// tb_cmos_decode_v2: randomized DVP frames scored against an event-level
// model, three parameter sets sharing one pin bus.
module tb_cmos_decode_v2;

    localparam int H = 4;
    localparam int V = 3;
    localparam int EV_DE   = 0;
    localparam int EV_LERR = 1;
    localparam int EV_FERR = 2;

    typedef struct {
        int k;
        int pix;
        int x;
        int y;
        int sof;
        int eol;
        int fc;
    } exp_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       href  = 1'b0;
    logic       vs    = 1'b0;
    logic [7:0] data  = 8'h00;

    logic [15:0] pix0;
    logic [15:0] pix1;
    logic [7:0]  pix2;
    logic        de[3];
    logic        sof[3];
    logic        eol[3];
    logic        oen[3];
    logic        lerr[3];
    logic        ferr[3];
    logic [1:0]  x[3];
    logic [1:0]  y[3];
    logic [15:0] fc[3];

    always #5 clk = ~clk;

    cmos_decode_v2 #(.DATA_W(8), .BYTES_PER_PIX(2), .MSB_FIRST(1),
        .FRAME_WAITCNT(2), .H_ACTIVE(H), .V_ACTIVE(V)) u0 (
        .cmos_pclk_i(clk), .rst_n_i(rst_n), .cmos_href_i(href),
        .cmos_vsync_i(vs), .cmos_data_i(data), .pix_o(pix0),
        .de_o(de[0]), .sof_o(sof[0]), .eol_o(eol[0]), .x_o(x[0]),
        .y_o(y[0]), .frame_cnt_o(fc[0]), .out_en_o(oen[0]),
        .line_err_o(lerr[0]), .frame_err_o(ferr[0]));

    cmos_decode_v2 #(.DATA_W(8), .BYTES_PER_PIX(2), .MSB_FIRST(0),
        .FRAME_WAITCNT(2), .H_ACTIVE(H), .V_ACTIVE(V)) u1 (
        .cmos_pclk_i(clk), .rst_n_i(rst_n), .cmos_href_i(href),
        .cmos_vsync_i(vs), .cmos_data_i(data), .pix_o(pix1),
        .de_o(de[1]), .sof_o(sof[1]), .eol_o(eol[1]), .x_o(x[1]),
        .y_o(y[1]), .frame_cnt_o(fc[1]), .out_en_o(oen[1]),
        .line_err_o(lerr[1]), .frame_err_o(ferr[1]));

    cmos_decode_v2 #(.DATA_W(8), .BYTES_PER_PIX(1), .MSB_FIRST(1),
        .FRAME_WAITCNT(0), .H_ACTIVE(H), .V_ACTIVE(V)) u2 (
        .cmos_pclk_i(clk), .rst_n_i(rst_n), .cmos_href_i(href),
        .cmos_vsync_i(vs), .cmos_data_i(data), .pix_o(pix2),
        .de_o(de[2]), .sof_o(sof[2]), .eol_o(eol[2]), .x_o(x[2]),
        .y_o(y[2]), .frame_cnt_o(fc[2]), .out_en_o(oen[2]),
        .line_err_o(lerr[2]), .frame_err_o(ferr[2]));

    int checks = 0;
    int errors = 0;
    int nde0   = 0;
    bit mon_en = 1'b0;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    // Reference model state, per instance: 0 warm-up, 1 sync, 2 in frame.
    int bpp[3] = '{2, 2, 1};
    int msb[3] = '{1, 0, 1};
    int wn[3]  = '{2, 2, 0};
    int mode[3];
    int wcnt[3];
    int lines[3];
    int fcnt[3];

    logic [7:0] lb[$];

    function automatic void cmp(input string nm, input int i,
                                input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s u%0d got %0h want %0h", nm, i, act, exp);
        end
    endfunction

    function automatic void push(input int i, input exp_t e);
        case (i)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endfunction

    function automatic int qn(input int i);
        case (i)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic exp_t pop(input int i);
        exp_t e;
        case (i)
            0:       e = q0.pop_front();
            1:       e = q1.pop_front();
            default: e = q2.pop_front();
        endcase
        return e;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) begin
            mode[i]  = (wn[i] == 0) ? 1 : 0;
            wcnt[i]  = 0;
            lines[i] = 0;
            fcnt[i]  = 0;
        end
        q0.delete();
        q1.delete();
        q2.delete();
    endfunction

    function automatic void model_line();
        for (int i = 0; i < 3; i++) begin
            if (mode[i] == 2) begin
                int np;
                int rm;
                exp_t e;
                np = lb.size() / bpp[i];
                rm = lb.size() % bpp[i];
                for (int p = 0; p < np; p++) begin
                    if (p < H && lines[i] < V) begin
                        e.k = EV_DE;
                        e.pix = 0;
                        for (int j = 0; j < bpp[i]; j++) begin
                            if (msb[i] != 0)
                                e.pix = e.pix * 256 + int'(lb[p*bpp[i]+j]);
                            else
                                e.pix = e.pix + (int'(lb[p*bpp[i]+j]) << (8*j));
                        end
                        e.x   = p;
                        e.y   = lines[i];
                        e.sof = (p == 0 && lines[i] == 0) ? 1 : 0;
                        e.eol = (p == H - 1) ? 1 : 0;
                        e.fc  = fcnt[i];
                        push(i, e);
                    end
                end
                if (np != H || rm != 0) begin
                    e.k  = EV_LERR;
                    e.fc = fcnt[i];
                    push(i, e);
                end
                lines[i]++;
            end
        end
    endfunction

    function automatic void model_vs();
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            case (mode[i])
                0: begin
                    wcnt[i]++;
                    if (wcnt[i] == wn[i]) mode[i] = 1;
                end
                1: begin
                    mode[i]  = 2;
                    lines[i] = 0;
                end
                default: begin
                    if (lines[i] != V) begin
                        e.k  = EV_FERR;
                        e.fc = fcnt[i];
                        push(i, e);
                    end else begin
                        fcnt[i]++;
                    end
                    lines[i] = 0;
                end
            endcase
        end
    endfunction

    function automatic void mon(input int i, input logic d, input logic [15:0] p,
                                input logic s, input logic eo, input logic [1:0] xx,
                                input logic [1:0] yy, input logic le, input logic fe,
                                input logic [15:0] f);
        exp_t e;
        if (d) begin
            cmp("de_expected", i, int'(qn(i) > 0), 1);
            if (qn(i) > 0) begin
                e = pop(i);
                cmp("de_kind", i, EV_DE, e.k);
                if (e.k == EV_DE) begin
                    cmp("pix", i, int'(p), e.pix);
                    cmp("x", i, int'(xx), e.x);
                    cmp("y", i, int'(yy), e.y);
                    cmp("sof", i, int'(s), e.sof);
                    cmp("eol", i, int'(eo), e.eol);
                    cmp("frame_cnt", i, int'(f), e.fc);
                end
            end
        end
        if (le) begin
            cmp("lerr_expected", i, int'(qn(i) > 0), 1);
            if (qn(i) > 0) begin
                e = pop(i);
                cmp("lerr_kind", i, EV_LERR, e.k);
            end
        end
        if (fe) begin
            cmp("ferr_expected", i, int'(qn(i) > 0), 1);
            if (qn(i) > 0) begin
                e = pop(i);
                cmp("ferr_kind", i, EV_FERR, e.k);
                if (e.k == EV_FERR) cmp("ferr_fcnt", i, int'(f), e.fc);
            end
        end
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            if (de[0]) nde0++;
            mon(0, de[0], pix0, sof[0], eol[0], x[0], y[0], lerr[0], ferr[0], fc[0]);
            mon(1, de[1], pix1, sof[1], eol[1], x[1], y[1], lerr[1], ferr[1], fc[1]);
            mon(2, de[2], {8'h00, pix2}, sof[2], eol[2], x[2], y[2], lerr[2],
                ferr[2], fc[2]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic build(input int n, input int p);
        lb.delete();
        for (int k = 0; k < n; k++) begin
            case (p)
                1:       lb.push_back((k % 2 == 0) ? 8'hA5 : 8'h3C);
                2:       lb.push_back(8'h7E);
                default: lb.push_back(8'($urandom));
            endcase
        end
    endtask

    task automatic drive(input bit vs_end);
        for (int k = 0; k < lb.size(); k++) begin
            href = 1'b1;
            data = lb[k];
            tick();
        end
        href = 1'b0;
        data = 8'($urandom);
        if (vs_end) vs = 1'b0;
        repeat ($urandom_range(5, 2)) tick();
    endtask

    task automatic line(input int n, input int p);
        build(n, p);
        model_line();
        drive(1'b0);
    endtask

    task automatic vs_pulse();
        vs = 1'b1;
        repeat (3) tick();
        vs = 1'b0;
        model_vs();
        repeat (3) tick();
    endtask

    task automatic frame(input int nl, input int n, input int p);
        for (int l = 0; l < nl; l++) line(n, p);
        vs_pulse();
    endtask

    task automatic warmup_and_first(input string tag);
        int n;
        frame(3, 8, 0);
        cmp({tag, "_oen_f1"}, 0, int'(oen[0]), 0);
        frame(3, 8, 0);
        cmp({tag, "_oen_f2"}, 0, int'(oen[0]), 1);
        frame(3, 8, 0);
        n = nde0;
        frame(3, 8, 0);
        cmp({tag, "_f4_strobes"}, 0, nde0 - n, 12);
        cmp({tag, "_f4_fcnt"}, 0, int'(fc[0]), 1);
    endtask

    initial begin
        int n;
        model_reset();
        repeat (3) tick();
        cmp("rst_pix", 0, int'(pix0), 0);
        cmp("rst_de", 0, int'(de[0]), 0);
        cmp("rst_oen", 0, int'(oen[0]), 0);
        cmp("rst_fc", 0, int'(fc[0]), 0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        tick();

        warmup_and_first("warm");
        cmp("warm_no_early_de", 0, nde0, 12);

        frame(3, 8, 1);
        cmp("pack_fcnt", 0, int'(fc[0]), 2);
        frame(3, 8, 2);

        line(6, 0);
        line(10, 0);
        line(9, 0);
        vs_pulse();

        n = int'(fc[0]);
        frame(2, 8, 0);
        cmp("short_frame_fcnt", 0, int'(fc[0]), n);
        n = nde0;
        frame(4, 8, 0);
        cmp("long_frame_strobes", 0, nde0 - n, 12);

        line(8, 0);
        line(8, 0);
        vs = 1'b1;
        repeat (3) tick();
        build(8, 0);
        model_line();
        model_vs();
        drive(1'b1);
        repeat (3) tick();
        frame(3, 8, 0);

        repeat (6) begin
            n = $urandom_range(4, 2);
            for (int l = 0; l < n; l++) line($urandom_range(10, 6), 0);
            vs_pulse();
        end
        repeat (4) tick();
        for (int i = 0; i < 3; i++) cmp("q_drained", i, qn(i), 0);

        mon_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            href = 1'b1;
            data = 8'($urandom);
            tick();
        end
        rst_n = 1'b0;
        #2;
        cmp("arst_pix", 0, int'(pix0), 0);
        cmp("arst_de", 0, int'(de[0]), 0);
        cmp("arst_sof", 0, int'(sof[0]), 0);
        cmp("arst_eol", 0, int'(eol[0]), 0);
        cmp("arst_x", 0, int'(x[0]), 0);
        cmp("arst_y", 0, int'(y[0]), 0);
        cmp("arst_fc", 0, int'(fc[0]), 0);
        cmp("arst_oen", 0, int'(oen[0]), 0);
        cmp("arst_lerr", 0, int'(lerr[0]), 0);
        cmp("arst_ferr", 0, int'(ferr[0]), 0);
        href = 1'b0;
        tick();
        model_reset();
        rst_n = 1'b1;
        tick();
        mon_en = 1'b1;
        warmup_and_first("rerun");

        repeat (6) tick();
        for (int i = 0; i < 3; i++) begin
            cmp("end_q_drained", i, qn(i), 0);
            cmp("end_fcnt", i, int'(fc[i]), fcnt[i]);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cmos_decode_v2.md
# cmos_decode_v2

Parametrised second-generation DVP camera front end for the OV5640 capture path. It samples the sensor's byte-serial pixel bus (href/vsync/data) on the pixel clock and packs 1–4 bytes into one pixel word. It tracks pixel and line position, checks every line and frame against the configured geometry, and gates output until a configurable number of warm-up frames has passed. It sits between the sensor pins and the binarisation/frame-buffer pipeline.

## Interface
- DATA_W, 8, sensor bus width in bits
- BYTES_PER_PIX, 2, bus beats per pixel (1..4; 2 = RGB565, 1 = Y8)
- MSB_FIRST, 1, 1: first beat lands in the top byte of pix_o; 0: first beat lands in the bottom byte
- FRAME_WAITCNT, 15, frame starts discarded before output is enabled (0..255)
- H_ACTIVE, 640, pixels per line
- V_ACTIVE, 480, lines per frame
- cmos_pclk_i  in  1  sensor pixel clock; the only clock
- rst_n_i  in  1  asynchronous active-low reset
- cmos_href_i  in  1  line valid, active high
- cmos_vsync_i  in  1  frame sync; a falling edge marks frame start
- cmos_data_i  in  DATA_W  sensor data
- pix_o  out  DATA_W*BYTES_PER_PIX  assembled pixel
- de_o  out  1  pix_o valid strobe
- sof_o  out  1  with de_o: first pixel of frame (x=0, y=0)
- eol_o  out  1  with de_o: last pixel of line (x=H_ACTIVE-1)
- x_o  out  clog2(H_ACTIVE)  column of the current pix_o
- y_o  out  clog2(V_ACTIVE)  row of the current pix_o
- frame_cnt_o  out  16  frames completed since out_en_o rose; wraps
- out_en_o  out  1  warm-up complete
- line_err_o  out  1  one-cycle pulse for a bad line length
- frame_err_o  out  1  one-cycle pulse for a bad line count

## Operation
- Input stage: href, vsync and data are registered once (stage S1). All logic runs off S1 signals. vs_fall = S1 vsync falling edge. href_fall = S1 href falling edge.
- States: WAIT, SYNC, FRAME.
  - WAIT: count each vs_fall in an 8-bit counter. When the count reaches FRAME_WAITCNT, set out_en_o and go to SYNC. With FRAME_WAITCNT=0, go straight to SYNC. out_en_o stays set until reset.
  - SYNC: wait for vs_fall. On vs_fall, clear the line counter and go to FRAME. This discards any partially seen frame.
  - FRAME: on each later vs_fall, compare the line count with V_ACTIVE. If they differ, pulse frame_err_o. Otherwise increment frame_cnt_o. Then restart the frame and stay in FRAME.
- Byte packing:
  - The beat counter clears while S1 href is low.
  - Each href-high beat shifts into the assembly register. Placement follows MSB_FIRST.
  - On beat BYTES_PER_PIX-1, the word transfers to pix_o and a pixel event is raised.
  - The beat counter wraps to 0.
- Column counter:
  - Counts pixel events and clears on href_fall.
  - Pixel events with column ≥ H_ACTIVE produce no de_o. The counter saturates at H_ACTIVE.
- Line close (href_fall) in FRAME: pulse line_err_o if the column ≠ H_ACTIVE or the beat counter ≠ 0 (partial pixel, which is discarded).
- Line counter:
  - Increments on each href_fall in FRAME and saturates at V_ACTIVE.
  - Lines whose index is ≥ V_ACTIVE produce no de_o. Their length errors are still flagged.
- de_o is asserted only in FRAME with out_en_o=1. Lines seen in WAIT or SYNC are ignored, including for error checks.
- vs_fall and href_fall in the same cycle: handle the line close first (against the old frame), then the frame restart. frame_err_o uses the line count including that line.
- Reset (any time, asynchronous): return to WAIT and restart the warm-up count.

## Timing
- Latency: the last beat of a pixel is on the pins at edge n and is registered in S1 at n. pix_o/de_o are registered at n+1 (visible in the cycle after n+1). sof_o, eol_o, x_o and y_o are aligned with de_o.
- de_o is a single-cycle pulse per pixel, so it is high at most 1 cycle in BYTES_PER_PIX. There is no back-pressure; downstream logic must accept every strobe.
- line_err_o fires 1 cycle after the S1 href fall edge. frame_err_o fires 1 cycle after vs_fall.
- Reset values:
  - pix_o = 0, de_o = 0, sof_o = 0, eol_o = 0, x_o = 0, y_o = 0
  - frame_cnt_o = 0, out_en_o = 0, line_err_o = 0, frame_err_o = 0
  - state = WAIT, all counters = 0
- pix_o holds its last value between strobes.

## Test plan
- Bench parameters: H_ACTIVE=4, V_ACTIVE=3, FRAME_WAITCNT=2, BYTES_PER_PIX=2, MSB_FIRST=1.
- Warm-up: 3 well-formed frames. Frames 1–2 must give de_o=0. Frame 3 must give no output because it is consumed by SYNC. Frame 4 must give 12 de_o pulses, with sof_o on the first and eol_o on pulses 4, 8 and 12. After frame 5 starts, frame_cnt_o=1.
- Packing: bytes A5,3C per pixel -> pix_o=A53C. With MSB_FIRST=0 -> 3CA5. With BYTES_PER_PIX=1, byte 7E -> pix_o=7E every beat.
- Short and long lines: a 3-pixel line -> line_err_o pulse and 3 strobes. A 5-pixel line -> line_err_o pulse and only 4 strobes (x_o 0..3). A line of 9 beats -> line_err_o pulse.
- Frame errors: 2 lines then vs_fall -> frame_err_o pulse, frame_cnt_o unchanged. 4 lines -> only 12 strobes, then frame_err_o.
- Simultaneous events and reset: href_fall and vs_fall in the same cycle -> the line is checked, then the new frame starts with y_o=0. Asserting rst_n_i mid-line -> all outputs 0 immediately, and out_en_o returns only after 2 further frame starts.
